// File: rtl/reg_file_scoreboard_pkg.sv
// Shared constants for the architectural register file and its in-flight write scoreboard.
package reg_file_scoreboard_pkg;

  localparam int unsigned REGISTER_FILE_LEN         = 32;
  localparam int unsigned REGISTER_FILE_ADDRESS_LEN = 4;
  localparam int unsigned SB_CNT_W                  = 2;
  localparam int unsigned REG_COUNT                 = 1 << REGISTER_FILE_ADDRESS_LEN;

endpackage

// File: rtl/reg_file_scoreboard_sb_counter.sv
// Per-register count of outstanding writes: up on accepted issue, down on retire.
module reg_file_scoreboard_sb_counter #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero_c,
  output logic             max_c,
  output logic             underflow_c
);

  assign zero_c      = (cnt == '0);
  assign max_c       = (cnt == '1);
  // A retire with nothing in flight leaves the count at zero and is flagged instead.
  assign underflow_c = dec & ~inc & zero_c;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && !dec) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc && !zero_c) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/reg_file_scoreboard.sv
// Register file with write-through read bypass and a per-register in-flight
// write scoreboard that stalls ID on RAW hazards and counter saturation.
module reg_file_scoreboard
  import reg_file_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W = REGISTER_FILE_LEN,
  parameter int unsigned ADDR_W = REGISTER_FILE_ADDRESS_LEN,
  parameter int unsigned CNT_W  = SB_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_wb_en,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic              two_src,
  input  logic              wb_enable,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic              hazard,
  output logic              issue_accept,
  output logic              sb_error
);

  localparam int unsigned NREGS = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREGS];
  logic [CNT_W-1:0]  cnt  [NREGS];
  logic [NREGS-1:0]  cnt_inc;
  logic [NREGS-1:0]  cnt_dec;
  logic [NREGS-1:0]  cnt_zero;
  logic [NREGS-1:0]  cnt_max;
  logic [NREGS-1:0]  cnt_underflow;
  logic              pend1;
  logic              pend2;
  logic              sat;

  // Register storage; reset seeds each register with its own index.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[i] <= DATA_W'(i);
      end
    end else if (wb_enable) begin
      regs[wb_dest] <= wb_value;
    end
  end

  assign reg1 = (wb_enable && (wb_dest == src1)) ? wb_value : regs[src1];
  assign reg2 = (wb_enable && (wb_dest == src2)) ? wb_value : regs[src2];

  for (genvar g = 0; g < int'(NREGS); g++) begin : g_cnt
    assign cnt_inc[g] = issue_accept & issue_wb_en & (issue_dest == ADDR_W'(g));
    assign cnt_dec[g] = wb_enable & (wb_dest == ADDR_W'(g));

    reg_file_scoreboard_sb_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk         (clk),
      .rst         (rst),
      .inc         (cnt_inc[g]),
      .dec         (cnt_dec[g]),
      .cnt         (cnt[g]),
      .zero_c      (cnt_zero[g]),
      .max_c       (cnt_max[g]),
      .underflow_c (cnt_underflow[g])
    );
  end

  // A source whose last outstanding write retires this cycle is served by the bypass.
  always_comb begin
    pend1        = 1'b0;
    pend2        = 1'b0;
    sat          = 1'b0;
    hazard       = 1'b0;
    issue_accept = 1'b0;
    pend1 = !cnt_zero[src1] &&
            !((cnt[src1] == CNT_W'(1)) && wb_enable && (wb_dest == src1));
    pend2 = !cnt_zero[src2] &&
            !((cnt[src2] == CNT_W'(1)) && wb_enable && (wb_dest == src2));
    sat   = issue_wb_en && cnt_max[issue_dest];
    if (issue_valid) begin
      hazard       = pend1 || (two_src && pend2) || sat;
      issue_accept = !hazard;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sb_error <= 1'b0;
    end else if (|cnt_underflow) begin
      sb_error <= 1'b1;
    end
  end

endmodule
